// File: rtl/pll_tune_ctrl.sv
// Tuning sequencer for a dynamically reconfigurable PLL: sweeps the ICP/LPF
// grid until lock holds stably, then watches for loss of lock and retunes.
module pll_tune_ctrl #(
  parameter int unsigned RESET_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT = 500000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOSS_FILTER  = 4,
  parameter int unsigned ICP_START    = 8,
  parameter int unsigned ICP_END      = 40,
  parameter int unsigned ICP_STEP     = 8,
  parameter int unsigned RES_START    = 0,
  parameter int unsigned RES_END      = 7,
  parameter logic [1:0]  LPF_CAP      = 2'b00,
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  output logic       locked,
  output logic       fail,
  output logic       busy
);

  localparam int unsigned ICP_W = 6;
  localparam int unsigned RES_W = 3;
  localparam int unsigned SUM_W = ICP_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ICP_W-1:0] icp_q, icp_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             sync1_q, lock_s_q;
  logic             first_q;
  logic             pll_reset_q, pll_reset_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic [1:0]       lpfcap_q;
  logic [SUM_W-1:0] icp_sum;
  logic             do_next;
  logic             restart;

  // Raw LOCK is asynchronous to clk: two-flop synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // Computed one bit wider so a step past ICP_END never wraps back into range
  assign icp_sum = SUM_W'(icp_q) + SUM_W'(ICP_STEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icp_d   = icp_q;
    res_d   = res_q;
    do_next = 1'b0;
    restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start || (AUTO_START && first_q)) restart = 1'b1;
      end
      S_APPLY: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          do_next = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          do_next = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOCKED: begin
        if (start) begin
          restart = 1'b1;
        end else if (lock_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOSS_FILTER - 1)) begin
          state_d = S_APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FAIL: begin
        if (start) restart = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Restart and grid advance both re-enter APPLY with a cleared counter
    if (restart) begin
      state_d = S_APPLY;
      cnt_d   = '0;
      icp_d   = ICP_W'(ICP_START);
      res_d   = RES_W'(RES_START);
    end else if (do_next) begin
      cnt_d = '0;
      if (icp_sum <= SUM_W'(ICP_END)) begin
        state_d = S_APPLY;
        icp_d   = icp_sum[ICP_W-1:0];
      end else if (res_q < RES_W'(RES_END)) begin
        state_d = S_APPLY;
        icp_d   = ICP_W'(ICP_START);
        res_d   = res_q + RES_W'(1);
      end else begin
        state_d = S_FAIL;
      end
    end

    pll_reset_d = (state_d == S_IDLE) || (state_d == S_APPLY) || (state_d == S_FAIL);
    locked_d    = (state_d == S_LOCKED);
    fail_d      = (state_d == S_FAIL);
    busy_d      = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_STABLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      icp_q       <= ICP_W'(ICP_START);
      res_q       <= RES_W'(RES_START);
      first_q     <= 1'b1;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      lpfcap_q    <= LPF_CAP;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      icp_q       <= icp_d;
      res_q       <= res_d;
      first_q     <= 1'b0;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      lpfcap_q    <= LPF_CAP;
    end
  end

  assign pll_reset = pll_reset_q;
  assign icpsel    = icp_q;
  assign lpfres    = res_q;
  assign lpfcap    = lpfcap_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pll_tune_ctrl.sv
// Bench for pll_tune_ctrl: behavioural PLL lock model, grid-order scoreboard,
// table-driven sweeps, random sweeps and hand-written loss/glitch/reset cases.
module tb_pll_tune_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       locked;
  logic       fail;
  logic       busy;

  pll_tune_ctrl #(
    .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .LOSS_FILTER(3),
    .ICP_START(8), .ICP_END(24), .ICP_STEP(8), .RES_START(2), .RES_END(3),
    .LPF_CAP(2'b00), .AUTO_START(1'b1), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .locked(locked), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       man = 1'b0;
  logic       man_lock = 1'b0;
  logic [5:0] tmask = 6'b000001;
  int         tdelay = 5;

  // Grid order: index = (lpfres-2)*3 + (icpsel-8)/8
  function automatic bit lockable(input logic [5:0] icp, input logic [2:0] res);
    int idx;
    if (icp < 6'd8 || icp > 6'd24 || (int'(icp) % 8) != 0 || res < 3'd2 || res > 3'd3) return 1'b0;
    idx = (int'(res) - 2) * 3 + (int'(icp) - 8) / 8;
    return tmask[idx];
  endfunction

  // PLL behaviour: locks tdelay cycles after reset release if the setting is lockable
  initial begin : pll_model
    int pcnt;
    int dly;
    pll_lock = 1'b0;
    pcnt = 0;
    dly = 1;
    forever begin
      @(negedge clk);
      #1;
      if (man) begin
        pll_lock = man_lock;
      end else if (pll_reset) begin
        pcnt = 0;
        pll_lock = 1'b0;
        dly = (tdelay == 0) ? int'($urandom_range(12, 1)) : tdelay;
      end else begin
        pcnt++;
        pll_lock = lockable(icpsel, lpfres) && (pcnt >= dly);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int  att_icp[$];
  int  att_res[$];
  int  att_cyc[$];
  bit  apply_prev = 1'b0;
  bit  lock_prev = 1'b0;
  bit  locked_prev = 1'b0;
  bit  busy_prev = 1'b0;
  int  apply_len = 0;
  int  apply_icp = 0;
  int  apply_res = 0;
  int  lock_rise_cyc = -1;
  int  locked_rise_cyc = -1;
  int  busy_before_locked = 0;

  // Advance to the next sampling point and update the transaction monitor
  task automatic step();
    bit apply_now;
    @(negedge clk);
    cyc++;
    chk("status_exclusive", int'(locked) + int'(fail) + int'(busy), (locked || fail || busy) ? 1 : 0);
    apply_now = busy && pll_reset;
    if (apply_now && !apply_prev) begin
      att_icp.push_back(int'(icpsel));
      att_res.push_back(int'(lpfres));
      att_cyc.push_back(cyc);
      apply_len = 0;
      apply_icp = int'(icpsel);
      apply_res = int'(lpfres);
    end
    if (apply_now) begin
      apply_len++;
      chk("apply_icp_hold", int'(icpsel), apply_icp);
      chk("apply_res_hold", int'(lpfres), apply_res);
    end
    if (!apply_now && apply_prev && !reset) chk("apply_len", apply_len, RC);
    if (pll_lock && !lock_prev) lock_rise_cyc = cyc;
    if (locked && !locked_prev) begin
      locked_rise_cyc = cyc;
      busy_before_locked = int'(busy_prev);
    end
    apply_prev  = apply_now;
    lock_prev   = pll_lock;
    locked_prev = locked;
    busy_prev   = busy;
  endtask

  // Reference outcome: first lockable grid point in sweep order wins
  task automatic ref_outcome(input logic [5:0] m, output bit lk, output int icp,
                             output int res, output int n);
    lk = 1'b0; n = 6; icp = 24; res = 3;
    for (int i = 5; i >= 0; i--) if (m[i]) begin lk = 1'b1; n = i + 1; end
    if (lk) begin
      icp = 8 + 8 * ((n - 1) % 3);
      res = 2 + (n - 1) / 3;
    end
  endtask

  task automatic run_trial(input string tag, input logic [5:0] mask, input int dly,
                           input bit via_reset, input bit exp_lock, input int exp_icp,
                           input int exp_res, input int exp_n);
    bit done;
    tmask = mask; tdelay = dly; man = 1'b0;
    att_icp.delete(); att_res.delete(); att_cyc.delete();
    locked_rise_cyc = -1;
    if (via_reset) begin
      reset = 1'b1;
      step(); step();
      chk({tag, "_rst_pll_reset"}, int'(pll_reset), 1);
      chk({tag, "_rst_icpsel"}, int'(icpsel), 8);
      chk({tag, "_rst_lpfres"}, int'(lpfres), 2);
      chk({tag, "_rst_lpfcap"}, int'(lpfcap), 0);
      chk({tag, "_rst_flags"}, int'({locked, fail, busy}), 0);
      reset = 1'b0;
    end else begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      done = locked || fail;
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_locked"}, int'(locked), int'(exp_lock));
    chk({tag, "_fail"}, int'(fail), int'(!exp_lock));
    chk({tag, "_pll_reset"}, int'(pll_reset), int'(!exp_lock));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_icpsel"}, int'(icpsel), exp_icp);
    chk({tag, "_lpfres"}, int'(lpfres), exp_res);
    chk({tag, "_attempts"}, att_icp.size(), exp_n);
    for (int i = 0; i < att_icp.size() && i < exp_n; i++) begin
      chk({tag, "_seq_icp"}, att_icp[i], 8 + 8 * (i % 3));
      chk({tag, "_seq_res"}, att_res[i], 2 + i / 3);
    end
    for (int i = 0; i + 1 < att_cyc.size(); i++)
      chk({tag, "_failed_attempt_len"}, att_cyc[i+1] - att_cyc[i], RC + LT);
    if (!exp_lock && att_cyc.size() > 0)
      chk({tag, "_last_attempt_len"}, cyc - att_cyc[att_cyc.size()-1], RC + LT);
    if (exp_lock) begin
      chk({tag, "_lock_to_locked"}, locked_rise_cyc - lock_rise_cyc, 10);
      chk({tag, "_busy_before_locked"}, busy_before_locked, 1);
    end
  endtask

  task automatic wait_locked(input string tag);
    int n;
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    chk({tag, "_relock"}, int'(locked), 1);
  endtask

  typedef struct {
    logic [5:0] mask;
    int         dly;
    bit         via_reset;
    bit         exp_lock;
    int         exp_icp;
    int         exp_res;
    int         exp_n;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    bit   lk;
    int   eicp, eres, en, n;
    logic [5:0] m;
    reset = 1'b1;
    start = 1'b0;

    tbl[0] = '{6'b000001, 5, 1'b1, 1'b1, 8,  2, 1};
    tbl[1] = '{6'b000100, 3, 1'b0, 1'b1, 24, 2, 3};
    tbl[2] = '{6'b000000, 4, 1'b0, 1'b0, 24, 3, 6};
    tbl[3] = '{6'b100010, 7, 1'b0, 1'b1, 16, 2, 2};
    tbl[4] = '{6'b001000, 0, 1'b0, 1'b1, 8,  3, 4};
    for (int i = 0; i < 5; i++)
      run_trial($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].dly, tbl[i].via_reset,
                tbl[i].exp_lock, tbl[i].exp_icp, tbl[i].exp_res, tbl[i].exp_n);

    for (int i = 0; i < 8; i++) begin
      m = 6'($urandom);
      ref_outcome(m, lk, eicp, eres, en);
      run_trial($sformatf("rnd%0d", i), m, int'($urandom_range(12, 0)), 1'b0, lk, eicp, eres, en);
    end

    // Loss-of-lock filtering in LOCKED
    run_trial("pre_loss", 6'b000001, 2, 1'b0, 1'b1, 8, 2, 1);
    man_lock = 1'b1; man = 1'b1;
    step(); step(); step();
    man_lock = 1'b0; step(); step(); man_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("loss2_hold_locked", int'(locked), 1);
    end
    man_lock = 1'b0; step(); step(); step(); man_lock = 1'b1;
    n = 0;
    while (locked && n < 10) begin step(); n++; end
    chk("loss3_unlocked", int'(locked), 0);
    chk("loss3_busy", int'(busy), 1);
    chk("loss3_pll_reset", int'(pll_reset), 1);
    chk("loss3_icpsel", int'(icpsel), 8);
    chk("loss3_lpfres", int'(lpfres), 2);
    n = 0;
    while (busy && pll_reset && n < 12) begin n++; step(); end
    chk("loss3_apply_len", n, RC);
    wait_locked("loss3");
    chk("loss3_relock_icpsel", int'(icpsel), 8);

    // One-cycle lock glitch during STABLE fails the attempt
    man_lock = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (pll_reset && n < 20) begin step(); n++; end
    chk("glitch_reached_wait", int'(pll_reset), 0);
    man_lock = 1'b1;
    for (int i = 0; i < 6; i++) step();
    man_lock = 1'b0; step(); man_lock = 1'b1;
    n = 0; lk = 1'b0;
    while (!(busy && pll_reset) && n < 40) begin
      step(); n++;
      if (locked) lk = 1'b1;
    end
    chk("glitch_no_lock", int'(lk), 0);
    chk("glitch_reapply", int'(busy && pll_reset), 1);
    chk("glitch_icpsel", int'(icpsel), 16);
    chk("glitch_lpfres", int'(lpfres), 2);
    wait_locked("glitch");
    chk("glitch_lock_icpsel", int'(icpsel), 16);

    // Asynchronous reset mid-WAIT at (16,3), then start ignored in APPLY
    tmask = 6'b100000; tdelay = 3; man = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(icpsel == 6'd16 && lpfres == 3'd3 && !pll_reset) && n < 300) begin step(); n++; end
    chk("rst_mid_reached_16_3", int'(icpsel == 6'd16 && lpfres == 3'd3 && !pll_reset), 1);
    step(); step(); step();
    chk("rst_mid_in_wait", int'({busy, pll_reset}), 2);
    reset = 1'b1;
    #1;
    chk("rst_async_pll_reset", int'(pll_reset), 1);
    chk("rst_async_icpsel", int'(icpsel), 8);
    chk("rst_async_lpfres", int'(lpfres), 2);
    chk("rst_async_flags", int'({locked, fail, busy}), 0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_restart_apply", int'(busy && pll_reset), 1);
    chk("rst_restart_icpsel", int'(icpsel), 8);
    chk("rst_restart_lpfres", int'(lpfres), 2);
    n = 0;
    while (busy && pll_reset && n < 12) begin n++; start = (n == 2); step(); end
    start = 1'b0;
    chk("start_in_apply_ignored_len", n, RC);
    chk("start_in_apply_icpsel", int'(icpsel), 8);
    n = 0;
    while (!(locked || fail) && n < 300) begin step(); n++; end
    chk("rst_sweep_locked", int'(locked), 1);
    chk("rst_sweep_icpsel", int'(icpsel), 24);
    chk("rst_sweep_lpfres", int'(lpfres), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_tune_ctrl.md
Name: pll_tune_ctrl

Overview:
Sequencer that sits directly upstream of the dynamically tuned PLL instance. It drives the PLL's reset and its dynamic charge-pump and loop-filter controls (ICPSEL/LPFRES/LPFCAP), and watches the PLL lock output. It sweeps a grid of ICP/LPF settings until lock holds stably, then monitors for loss of lock and retunes. It runs on the free-running 50 MHz reference clock that also feeds the PLL's CLKIN.

Parameters:
RESET_CYCLES, 64, cycles pll_reset is held high per attempt (1..2^CNT_W-1)
LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK before the attempt fails
LOCK_STABLE, 1024, consecutive synchronized-lock cycles required to declare lock
LOSS_FILTER, 4, consecutive unlocked cycles in LOCKED that count as loss of lock
ICP_START, 8, first icpsel value
ICP_END, 40, last icpsel value (must be >= ICP_START, <= 63)
ICP_STEP, 8, icpsel increment (>= 1)
RES_START, 0, first lpfres value
RES_END, 7, last lpfres value (must be >= RES_START)
LPF_CAP, 2'b00, constant lpfcap value
AUTO_START, 1, when 1, begin a sweep on the first cycle after reset release
CNT_W, 24, width of the shared cycle counter

Ports:
clk  in  1  reference clock, also the PLL CLKIN
reset  in  1  asynchronous, active-high; all state cleared
start  in  1  single-cycle pulse requesting a new sweep from the start values
pll_lock  in  1  raw PLL LOCK (asynchronous to clk; double-flop synchronized inside)
pll_reset  out  1  PLL RESET
icpsel  out  6  PLL ICPSEL
lpfres  out  3  PLL LPFRES
lpfcap  out  2  PLL LPFCAP, always LPF_CAP
locked  out  1  high only in LOCKED state
fail  out  1  high in FAIL state (grid exhausted)
busy  out  1  high in APPLY/WAIT_LOCK/STABLE

Behaviour:
- Reset values: pll_reset=1, icpsel=ICP_START, lpfres=RES_START, lpfcap=LPF_CAP, locked=0, fail=0, busy=0, state=IDLE, counter=0, sync flops=0. All outputs are registered.
- lock_s is pll_lock after two flops, giving 2 cycles of latency.
- IDLE: pll_reset=1. Go to APPLY with the start values on start, or on the first post-reset cycle if AUTO_START=1.
- APPLY: pll_reset=1, busy=1. icpsel/lpfres change only on the entry cycle, so settings are stable under reset. Stay exactly RESET_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: pll_reset=0; the counter increments each cycle.
  - lock_s=1: go to STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 without lock: take NEXT.
- STABLE: the counter counts consecutive lock_s=1 cycles.
  - Reaches LOCK_STABLE: go to LOCKED.
  - Any lock_s=0: take NEXT. A lock glitch fails the attempt.
- NEXT is a single decision performed on the transition, not a state:
  - icpsel+ICP_STEP <= ICP_END (computed 7-bit, no wrap): icpsel += ICP_STEP, go to APPLY.
  - Otherwise, if lpfres < RES_END: icpsel=ICP_START, lpfres += 1, go to APPLY.
  - Otherwise: go to FAIL, settings unchanged.
- LOCKED: locked=1, pll_reset=0. Count consecutive lock_s=0 cycles; any lock_s=1 clears the count. At LOSS_FILTER, locked=0 and go to APPLY with the same settings. The retry keeps the current grid position; a retry failure continues the sweep from there.
- FAIL: fail=1, pll_reset=1. Leave only on start.
- start is honoured in IDLE, LOCKED and FAIL; it restarts from ICP_START/RES_START via APPLY. start is ignored in APPLY, WAIT_LOCK and STABLE.
- If start and loss-of-lock qualify in the same cycle, start wins.
- Reset asserted mid-sweep: asynchronously forces pll_reset=1 and all reset values; the sweep restarts per AUTO_START.
- locked, fail and busy are mutually exclusive; at most one is high.

Test Plan:
Bench parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, LOSS_FILTER=3, ICP 8..24 step 8, RES 2..3, AUTO_START=1.
1. Release reset; model raises pll_lock 5 cycles after pll_reset falls -> pll_reset high 4 cycles with icpsel=8, lpfres=2; locked rises 2+8 cycles after pll_lock; busy falls the same cycle.
2. pll_lock only rises when icpsel=24 -> sequence icpsel 8, 16, 24 at lpfres=2; each failed attempt lasts 4+20 cycles; locked ends with icpsel=24, lpfres=2.
3. pll_lock never rises -> sequence (8,2)(16,2)(24,2)(8,3)(16,3)(24,3); fail=1, pll_reset=1, busy=0; a later start restarts at (8,2).
4. In LOCKED, drop pll_lock for 2 cycles -> locked stays 1. Drop it for 3 cycles -> locked=0, then APPLY with unchanged settings and pll_reset high 4 cycles.
5. In STABLE, 1-cycle pll_lock glitch after 5 good cycles -> the attempt fails and icpsel advances by 8.
6. Assert reset during WAIT_LOCK at (16,3) -> pll_reset=1 immediately (asynchronous); after release the sweep restarts at (8,2). A start pulse during APPLY has no effect.
